// File: rtl/dly_calib_pkg.sv
// Shared types and defaults for the delay-line tap calibration sequencer.
// Holds the FSM state encoding and the default NTAP/SETTLE/SAMPLES values.
package dly_calib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_EVAL   = 2'd3
    } state_t;

    localparam int NTAP_DEF    = 16;
    localparam int SETTLE_DEF  = 8;
    localparam int SAMPLES_DEF = 64;

endpackage

// File: rtl/dly_majority_cnt.sv
// Per-tap majority vote: counts pd_in ones over SAMPLES enabled cycles.
// Ports: clk, rstn, clr (zero counters), en (take a sample), pd_in,
//        last (final sample this cycle), hi (2*ones >= SAMPLES).
module dly_majority_cnt
    import dly_calib_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic pd_in,
    output logic last,
    output logic hi
);

    localparam int CNTW = $clog2(SAMPLES + 1);

    logic [CNTW-1:0] ones;
    logic [CNTW-1:0] scnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ones <= '0;
            scnt <= '0;
        end else if (clr) begin
            ones <= '0;
            scnt <= '0;
        end else if (en) begin
            ones <= ones + CNTW'(pd_in);
            scnt <= scnt + CNTW'(1);
        end
    end

    assign last = en && (scnt == CNTW'(SAMPLES - 1));

    // Doubling avoids a divide; an exact half counts as high.
    assign hi = {ones, 1'b0} >= (CNTW + 1)'(SAMPLES);

endmodule

// File: rtl/dly_tap_calib_ctrl.sv
// Calibration sequencer: sweeps delay-line taps, votes pd_in per tap and
// locks on the first low->high transition. Ports: clk, rstn, start, pd_in,
// force_en, force_tap -> tap_sel, busy, done, locked, lock_tap, err.
module dly_tap_calib_ctrl
    import dly_calib_pkg::*;
#(
    parameter int NTAP    = NTAP_DEF,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int SAMPLES = SAMPLES_DEF,
    localparam int TAPW   = $clog2(NTAP)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            pd_in,
    input  logic            force_en,
    input  logic [TAPW-1:0] force_tap,
    output logic [TAPW-1:0] tap_sel,
    output logic            busy,
    output logic            done,
    output logic            locked,
    output logic [TAPW-1:0] lock_tap,
    output logic            err
);

    localparam int SW = $clog2(SETTLE + 1);

    state_t          state;
    logic [SW-1:0]   scnt;
    logic            prev_hi;
    logic            force_q;
    logic            m_last;
    logic            m_hi;

    dly_majority_cnt #(
        .SAMPLES (SAMPLES)
    ) u_maj (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (state == ST_SETTLE),
        .en    (state == ST_SAMPLE),
        .pd_in (pd_in),
        .last  (m_last),
        .hi    (m_hi)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            scnt     <= '0;
            prev_hi  <= 1'b0;
            force_q  <= 1'b0;
            tap_sel  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            locked   <= 1'b0;
            lock_tap <= '0;
            err      <= 1'b0;
        end else begin
            done    <= 1'b0;
            force_q <= force_en;
            if (force_en) begin
                // Manual override wins over everything, aborting a sweep.
                tap_sel <= force_tap;
                if (state != ST_IDLE) begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    locked <= 1'b0;
                    err    <= 1'b0;
                end
            end else if (force_q) begin
                tap_sel <= locked ? lock_tap : '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            tap_sel <= '0;
                            locked  <= 1'b0;
                            err     <= 1'b0;
                            prev_hi <= 1'b0;
                            scnt    <= '0;
                            busy    <= 1'b1;
                            state   <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (scnt == SW'(SETTLE - 1)) begin
                            scnt  <= '0;
                            state <= ST_SAMPLE;
                        end else begin
                            scnt <= scnt + SW'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        if (m_last) state <= ST_EVAL;
                    end
                    ST_EVAL: begin
                        // Tap 0 has no preceding low, so it never locks.
                        if (m_hi && !prev_hi && tap_sel != '0) begin
                            lock_tap <= tap_sel;
                            locked   <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else if (tap_sel == TAPW'(NTAP - 1)) begin
                            err     <= 1'b1;
                            tap_sel <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            prev_hi <= m_hi;
                            tap_sel <= tap_sel + TAPW'(1);
                            scnt    <= '0;
                            state   <= ST_SETTLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dly_tap_calib_ctrl.sv
// Randomized scoreboard bench for dly_tap_calib_ctrl.
// Stimulus pushes expected results; a negedge monitor checks each done.
module tb_dly_tap_calib_ctrl;

    localparam int NTAP    = 16;
    localparam int SETTLE  = 8;
    localparam int SAMPLES = 64;
    localparam int TPT     = SETTLE + SAMPLES + 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       pd_in = 1'b0;
    logic       force_en = 1'b0;
    logic [3:0] force_tap = '0;
    logic [3:0] tap_sel;
    logic [3:0] lock_tap;
    logic       busy;
    logic       done;
    logic       locked;
    logic       err;

    dly_tap_calib_ctrl #(
        .NTAP    (NTAP),
        .SETTLE  (SETTLE),
        .SAMPLES (SAMPLES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .pd_in     (pd_in),
        .force_en  (force_en),
        .force_tap (force_tap),
        .tap_sel   (tap_sel),
        .busy      (busy),
        .done      (done),
        .locked    (locked),
        .lock_tap  (lock_tap),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit locked;
        bit err;
        int lock_tap;
        int tap_sel;
        int lat;
    } exp_t;

    exp_t q[$];
    exp_t m;
    exp_t last_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   nones[NTAP];
    int   phase = 0;
    int   prev_tap = 0;
    bit   start_fl = 1'b0;
    bit   done_q = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    // Reference: first tap t>=1 whose vote is high while tap t-1 was low.
    function automatic exp_t model();
        exp_t e;
        bit   hi[NTAP];
        for (int t = 0; t < NTAP; t++) hi[t] = (2 * nones[t] >= SAMPLES);
        e.locked   = 1'b0;
        e.err      = 1'b1;
        e.lock_tap = 0;
        e.tap_sel  = 0;
        e.lat      = NTAP * TPT;
        for (int t = 1; t < NTAP; t++) begin
            if (hi[t] && !hi[t-1]) begin
                e.locked   = 1'b1;
                e.err      = 1'b0;
                e.lock_tap = t;
                e.tap_sel  = t;
                e.lat      = (t + 1) * TPT;
                break;
            end
        end
        return e;
    endfunction

    // Per tap, the first nones[t] sample slots after settling carry a one.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        if (start_fl || int'(tap_sel) != prev_tap) phase = 0;
        else phase++;
        prev_tap = int'(tap_sel);
        start_fl = 1'b0;
        pd_in = (phase >= SETTLE) && (phase - SETTLE < nones[tap_sel]);
    endtask

    task automatic do_start();
        exp_t e;
        start = 1'b1;
        if (!force_en) begin
            start_fl = 1'b1;
            e = model();
            last_e = e;
            q.push_back(e);
        end
        tick();
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("done timeout", q.size(), 0);
        q.delete();
        tick();
    endtask

    task automatic wait_tap(input int t);
        int k = 0;
        while (int'(tap_sel) != t && k < 2000) begin
            tick();
            k++;
        end
        chk("reach tap", int'(tap_sel), t);
    endtask

    task automatic set_step(input int th);
        for (int t = 0; t < NTAP; t++) nones[t] = (t >= th) ? SAMPLES : 0;
    endtask

    always @(negedge clk) begin
        if (rstn && done) begin
            if (q.size() == 0) begin
                chk("unexpected done", 1, 0);
            end else begin
                m = q.pop_front();
                chk("locked", int'(locked), int'(m.locked));
                chk("err", int'(err), int'(m.err));
                if (m.locked) chk("lock_tap", int'(lock_tap), m.lock_tap);
                chk("tap_sel", int'(tap_sel), m.tap_sel);
                chk("busy at done", int'(busy), 0);
                chk("latency", cyc - start_cyc, m.lat);
            end
            if (done_q) chk("done width", 1, 0);
        end
        done_q = rstn && done;
    end

    initial begin
        #2;
        chk("reset outputs",
            int'({tap_sel, busy, done, locked, lock_tap, err}), 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Reset in SAMPLE at tap 5, then restart from tap 0.
        set_step(NTAP);
        do_start();
        wait_tap(5);
        repeat (20) tick();
        chk("busy mid sweep", int'(busy), 1);
        q.delete();
        rstn = 1'b0;
        #1;
        chk("mid reset outputs",
            int'({tap_sel, busy, done, locked, lock_tap, err}), 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Step at tap 6.
        set_step(6);
        do_start();
        wait_idle(NTAP * TPT + 20);

        // Always high: tap 0 high gives no rise.
        set_step(0);
        do_start();
        wait_idle(NTAP * TPT + 20);

        // Tie at tap 3 counts high.
        for (int t = 0; t < NTAP; t++) nones[t] = (t < 3) ? 31 : 32;
        do_start();
        repeat (100) tick();
        start = 1'b1;
        tick();
        wait_idle(NTAP * TPT + 20);

        // Force during tap 4 aborts with no done.
        set_step(NTAP);
        do_start();
        wait_tap(4);
        repeat (30) tick();
        q.delete();
        force_en = 1'b1;
        force_tap = 4'd9;
        tick();
        chk("abort busy", int'(busy), 0);
        chk("force tap", int'(tap_sel), 9);
        do_start();
        repeat (5) tick();
        chk("start under force", int'(busy), 0);
        force_tap = 4'd3;
        tick();
        chk("force tap 3", int'(tap_sel), 3);
        force_en = 1'b0;
        tick();
        chk("release no lock", int'(tap_sel), 0);
        chk("abort locked", int'(locked), 0);
        chk("abort err", int'(err), 0);
        repeat (200) tick();

        // Release after a lock returns to lock_tap.
        set_step(6);
        do_start();
        wait_idle(NTAP * TPT + 20);
        force_en = 1'b1;
        force_tap = 4'd2;
        tick();
        chk("force tap 2", int'(tap_sel), 2);
        force_en = 1'b0;
        tick();
        chk("release to lock", int'(tap_sel), last_e.lock_tap);
        chk("lock kept", int'(locked), 1);

        // Randomized per-tap vote counts.
        for (int r = 0; r < 10; r++) begin
            for (int t = 0; t < NTAP; t++) begin
                case ($urandom_range(0, 5))
                    0: nones[t] = 0;
                    1: nones[t] = SAMPLES;
                    2: nones[t] = 31;
                    3: nones[t] = 32;
                    4: nones[t] = 33;
                    default: nones[t] = $urandom_range(0, SAMPLES);
                endcase
            end
            do_start();
            wait_idle(NTAP * TPT + 20);
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
